multicycle_control: RTL and testbench

Main control state machine for the multicycle MIPS datapath. It decodes the instruction-register fields and sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the write enables and the 4-bit ALU operation code, and it consumes the ALU `zero` flag to resolve branches. Memory accesses stall on a ready handshake, and unsupported encodings trap.

---
 rtl/multicycle_control_pkg.sv | 87 ++++++++
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control_alu_decoder.sv | 30 +++
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared constants and types for the multicycle MIPS main control unit:
// ALU operation codes, instruction opcode/funct values, FSM state encoding
// and the bundle of control outputs driven every cycle.
package multicycle_control_pkg;

    // ALU operation codes. ADDU is encoded as zero so that an all-zero
    // control word (RESET, TRAP) still presents the ADDU default.
    typedef enum logic [3:0] {
        ALU_OP_ADDU = 4'd0,
        ALU_OP_ADD  = 4'd1,
        ALU_OP_SUBU = 4'd2,
        ALU_OP_SUB  = 4'd3,
        ALU_OP_AND  = 4'd4,
        ALU_OP_OR   = 4'd5,
        ALU_OP_NOR  = 4'd6,
        ALU_OP_SLT  = 4'd7
    } alu_op_e;

    // Primary opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, IR[5:0]
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    // ALU operand A select
    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_REG = 1'b1;

    // PC next-value select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Main FSM states
    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPEEX  = 4'd7,
        S_RTYPEWB  = 4'd8,
        S_BEQEX    = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JEX      = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    // Complete control word produced each cycle
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_op_e    alu_opcode;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the main control FSM and the multicycle datapath.
// master = control unit (drives enables/selects), slave = datapath.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;

    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_opcode;
    logic       illegal;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_opcode, illegal
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
               alu_opcode, illegal
    );

endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational R-type funct decoder: maps funct to an ALU operation and
// flags whether the funct is one the datapath supports.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output logic       funct_ok
);

    // Funct lookup; unsupported codes fall back to ADDU and clear funct_ok
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a variable unassigned, which would infer a latch.
        alu_op   = ALU_OP_ADDU;
        funct_ok = 1'b1;
        case (funct)
            FUNCT_ADD:  alu_op = ALU_OP_ADD;
            FUNCT_ADDU: alu_op = ALU_OP_ADDU;
            FUNCT_SUB:  alu_op = ALU_OP_SUB;
            FUNCT_SUBU: alu_op = ALU_OP_SUBU;
            FUNCT_AND:  alu_op = ALU_OP_AND;
            FUNCT_OR:   alu_op = ALU_OP_OR;
            FUNCT_NOR:  alu_op = ALU_OP_NOR;
            FUNCT_SLT:  alu_op = ALU_OP_SLT;
            default:    funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback, stalls on
// mem_ready in the memory states and parks in TRAP on unsupported encodings.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    // The control logic is width-independent; WORD_SIZE only documents the
    // ALU width, so it is merely sanity-checked here.
    if (WORD_SIZE < 1) begin : g_bad_word_size
        $error("multicycle_control: WORD_SIZE must be positive");
    end

    state_e  state;
    state_e  state_next;
    ctrl_t   ctrl;
    logic    is_store;
    alu_op_e dec_alu_op;
    logic    dec_funct_ok;

    alu_decoder u_alu_decoder (
        .funct    (bus.funct),
        .alu_op   (dec_alu_op),
        .funct_ok (dec_funct_ok)
    );

    // State register; rst forces RESET immediately so all outputs drop
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) state <= S_RESET;
        else     state <= state_next;
    end

    // Remember lw vs sw in DECODE; opcode is not trusted after that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    is_store <= 1'b0;
        else if (state == S_DECODE) is_store <= (bus.opcode == OP_SW);
    end

    // Next-state and Moore control decode
    always_comb begin
        state_next      = state;
        ctrl            = '0;
        ctrl.alu_opcode = ALU_OP_ADDU;

        case (state)
            S_RESET: begin
                state_next = S_FETCH;
            end

            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_next = S_DECODE;
            end

            S_DECODE: begin
                // Branch target precomputed while the opcode is decoded
                ctrl.alu_src_a = SRC_A_PC;
                ctrl.alu_src_b = SRC_B_IMM_SH2;
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = dec_funct_ok ? S_RTYPEEX : S_TRAP;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_TRAP;
                endcase
            end

            S_MEMADR: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_IMM;
                ctrl.alu_opcode = ALU_OP_ADD;
                state_next      = is_store ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
                if (bus.mem_ready) state_next = S_MEMWB;
            end

            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end

            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (bus.mem_ready) state_next = S_FETCH;
            end

            S_RTYPEEX: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_REG;
                ctrl.alu_opcode = dec_alu_op;
                state_next      = S_RTYPEWB;
            end

            S_RTYPEWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end

            S_BEQEX: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_REG;
                ctrl.alu_opcode = ALU_OP_SUBU;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.pc_write   = bus.alu_zero;
                state_next      = S_FETCH;
            end

            S_ADDIEX: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_IMM;
                ctrl.alu_opcode = ALU_OP_ADD;
                state_next      = S_ADDIWB;
            end

            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                state_next      = S_FETCH;
            end

            S_JEX: begin
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.pc_write = 1'b1;
                state_next    = S_FETCH;
            end

            S_TRAP: begin
                // Sticky until reset
                ctrl.illegal = 1'b1;
            end

            default: begin
                state_next = S_RESET;
            end
        endcase
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.alu_opcode = ctrl.alu_opcode;
    assign bus.illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. An instruction-level model
// expands each instruction into its expected per-cycle control words and
// queues them; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic       pcw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rdst;
        logic       m2r;
        logic       rw;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic [3:0] op;
        logic       ill;
    } ov_t;

    typedef struct {
        string nm;
        ov_t   v;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    multicycle_control_if bus ();

    multicycle_control #(.WORD_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ov_t got_now();
        ov_t g;
        g.pcw  = bus.pc_write;
        g.iord = bus.iord;
        g.mrd  = bus.mem_read;
        g.mwr  = bus.mem_write;
        g.irw  = bus.ir_write;
        g.rdst = bus.reg_dst;
        g.m2r  = bus.mem_to_reg;
        g.rw   = bus.reg_write;
        g.sa   = bus.alu_src_a;
        g.sb   = bus.alu_src_b;
        g.ps   = bus.pc_src;
        g.op   = bus.alu_opcode;
        g.ill  = bus.illegal;
        return g;
    endfunction

    task automatic check(input string nm, input ov_t got, input ov_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %b required %b", nm, $time, got, exp);
        end
    endtask

    // Monitor: one queued expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.nm, got_now(), e.v);
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    // Spec funct table for the reference model
    function automatic bit ref_funct(input logic [5:0] fn, output logic [3:0] aop);
        aop = ALU_OP_ADDU;
        case (fn)
            6'h20: begin aop = ALU_OP_ADD;  return 1'b1; end
            6'h21: begin aop = ALU_OP_ADDU; return 1'b1; end
            6'h22: begin aop = ALU_OP_SUB;  return 1'b1; end
            6'h23: begin aop = ALU_OP_SUBU; return 1'b1; end
            6'h24: begin aop = ALU_OP_AND;  return 1'b1; end
            6'h25: begin aop = ALU_OP_OR;   return 1'b1; end
            6'h27: begin aop = ALU_OP_NOR;  return 1'b1; end
            6'h2A: begin aop = ALU_OP_SLT;  return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic ov_t fetch_out(input logic rdy);
        ov_t o;
        o     = '0;
        o.mrd = 1'b1;
        o.sb  = 2'b01;
        o.op  = ALU_OP_ADDU;
        o.pcw = rdy;
        o.irw = rdy;
        return o;
    endfunction

    // Drive one cycle's inputs just after the rising edge and queue the
    // control word expected during that cycle
    task automatic cyc(input string nm, input logic rdy, input logic zr,
                       input logic [5:0] op, input logic [5:0] fn, input ov_t exp);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        bus.alu_zero  = zr;
        bus.opcode    = op;
        bus.funct     = fn;
        e.nm = nm;
        e.v  = exp;
        exp_q.push_back(e);
    endtask

    // Assert rst mid-cycle, confirm outputs clear at once, then release
    // and expect one RESET cycle of all-zero outputs
    task automatic do_reset(input logic rdy);
        exp_t e;
        @(posedge clk);
        #1;
        bus.mem_ready = rdy;
        bus.alu_zero  = rbit();
        #2;
        rst = 1'b1;
        #1;
        check("reset_async_outputs", got_now(), '0);
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        e.nm = "reset_state";
        e.v  = '0;
        exp_q.push_back(e);
    endtask

    // Instruction-level reference model
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic zero, input int fstall, input int mstall,
                             input int trap_cycles, input bit abort_mem);
        ov_t        o;
        logic [3:0] aop;
        bit         fok;
        bit         is_lw;

        for (int i = 0; i < fstall; i++)
            cyc("fetch_stall", 1'b0, rbit(), rop(), rop(), fetch_out(1'b0));
        cyc("fetch", 1'b1, rbit(), rop(), rop(), fetch_out(1'b1));

        o = '0; o.sb = 2'b11; o.op = ALU_OP_ADDU;
        cyc("decode", rbit(), rbit(), op, fn, o);

        fok = ref_funct(fn, aop);

        if (op == 6'h00 && fok) begin
            o = '0; o.sa = 1'b1; o.sb = 2'b00; o.op = aop;
            cyc("rtype_ex", rbit(), rbit(), rop(), fn, o);
            o = '0; o.rdst = 1'b1; o.rw = 1'b1;
            cyc("rtype_wb", rbit(), rbit(), rop(), rop(), o);
        end else if (op == 6'h08) begin
            o = '0; o.sa = 1'b1; o.sb = 2'b10; o.op = ALU_OP_ADD;
            cyc("addi_ex", rbit(), rbit(), rop(), rop(), o);
            o = '0; o.rw = 1'b1;
            cyc("addi_wb", rbit(), rbit(), rop(), rop(), o);
        end else if (op == 6'h04) begin
            o = '0; o.sa = 1'b1; o.sb = 2'b00; o.op = ALU_OP_SUBU; o.ps = 2'b01; o.pcw = zero;
            cyc("beq_ex", rbit(), zero, rop(), rop(), o);
        end else if (op == 6'h02) begin
            o = '0; o.ps = 2'b10; o.pcw = 1'b1;
            cyc("j_ex", rbit(), rbit(), rop(), rop(), o);
        end else if (op == 6'h23 || op == 6'h2B) begin
            is_lw = (op == 6'h23);
            o = '0; o.sa = 1'b1; o.sb = 2'b10; o.op = ALU_OP_ADD;
            cyc("mem_adr", rbit(), rbit(), rop(), rop(), o);
            o = '0; o.iord = 1'b1; o.mrd = is_lw; o.mwr = !is_lw;
            for (int i = 0; i < mstall; i++)
                cyc(is_lw ? "mem_rd_stall" : "mem_wr_stall", 1'b0, rbit(), rop(), rop(), o);
            if (abort_mem) begin
                do_reset(1'b0);
                return;
            end
            cyc(is_lw ? "mem_rd" : "mem_wr", 1'b1, rbit(), rop(), rop(), o);
            if (is_lw) begin
                o = '0; o.m2r = 1'b1; o.rw = 1'b1;
                cyc("mem_wb", rbit(), rbit(), rop(), rop(), o);
            end
        end else begin
            o = '0; o.ill = 1'b1;
            for (int i = 0; i < trap_cycles; i++)
                cyc("trap", rbit(), rbit(), rop(), rop(), o);
            do_reset(rbit());
        end
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] fns[9];
        logic [5:0] bad_ops[4];
        int         pick;
        logic [5:0] op;
        logic [5:0] fn;

        ops     = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
        fns     = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h26};
        bad_ops = '{6'h01, 6'h3F, 6'h10, 6'h22};

        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        bus.alu_zero  = 1'b0;
        bus.mem_ready = 1'b0;

        // Power-on reset
        #2;
        rst = 1'b1;
        #1;
        check("reset_initial_outputs", got_now(), '0);
        begin
            exp_t e;
            repeat (2) @(posedge clk);
            #1;
            rst  = 1'b0;
            e.nm = "reset_state";
            e.v  = '0;
            exp_q.push_back(e);
        end

        // Directed cases
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 1'b0);   // add
        run_instr(6'h23, 6'h00, 1'b0, 0, 2, 0, 1'b0);   // lw, 2-cycle stall
        run_instr(6'h04, 6'h00, 1'b1, 0, 0, 0, 1'b0);   // beq taken
        run_instr(6'h04, 6'h00, 1'b0, 0, 0, 0, 1'b0);   // beq not taken
        run_instr(6'h2B, 6'h00, 1'b0, 0, 0, 0, 1'b0);   // sw
        run_instr(6'h02, 6'h00, 1'b0, 0, 0, 0, 1'b0);   // j
        run_instr(6'h08, 6'h00, 1'b0, 2, 0, 0, 1'b0);   // addi, fetch stall
        run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 100, 1'b0); // illegal opcode
        run_instr(6'h00, 6'h26, 1'b0, 0, 0, 100, 1'b0); // illegal funct
        run_instr(6'h2B, 6'h00, 1'b0, 0, 2, 0, 1'b1);   // rst during sw stall
        run_instr(6'h00, 6'h2A, 1'b0, 0, 0, 0, 1'b0);   // slt after reset

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 13);
            if (pick < 4) begin
                op = 6'h00;
                fn = fns[$urandom_range(0, 8)];
            end else if (pick == 13) begin
                op = bad_ops[$urandom_range(0, 3)];
                fn = rop();
            end else begin
                op = ops[$urandom_range(1, 5)];
                fn = rop();
            end
            run_instr(op, fn, rbit(), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(3, 8), 1'b0);
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
